// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared types and reset/exception vectors for the fetch PC and CP0 blocks.
package pc_gen_pkg;
  typedef enum logic {NORMAL, HANDLER} state_t;
  typedef enum logic [2:0] {SEL_EXC, SEL_ERET, SEL_BR, SEL_JMP, SEL_HOLD, SEL_SEQ} sel_t;
  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_4180;
endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: priority encoder choosing the next-PC source and the matching mux.
import pc_gen_pkg::*;
module pc_next_sel #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] EXC_VEC = DEF_EXC_VEC,
  parameter int INC = 4
) (
  input  logic             in_handler,
  input  logic             stall_i,
  input  logic             br_taken_i,
  input  logic [WIDTH-1:0] br_target_i,
  input  logic             jmp_i,
  input  logic [WIDTH-1:0] jmp_target_i,
  input  logic             exc_req_i,
  input  logic             eret_i,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] epc,
  output sel_t             sel,
  output logic [WIDTH-1:0] next_pc
);
  // Masked requests (exc in HANDLER, eret in NORMAL) fall through to lower priorities.
  always_comb begin
    sel = (exc_req_i && !in_handler) ? SEL_EXC :
          (eret_i && in_handler)     ? SEL_ERET :
          br_taken_i                 ? SEL_BR :
          jmp_i                      ? SEL_JMP :
          stall_i                    ? SEL_HOLD : SEL_SEQ;
    next_pc = (sel == SEL_EXC)  ? EXC_VEC :
              (sel == SEL_ERET) ? epc :
              (sel == SEL_BR)   ? br_target_i :
              (sel == SEL_JMP)  ? jmp_target_i :
              (sel == SEL_HOLD) ? pc : pc + WIDTH'(INC);
  end
endmodule

// File: rtl/pc_gen.sv
// pc_gen: IF-stage program counter with branch/jump/exception/ERET redirects and handler tracking.
import pc_gen_pkg::*;
module pc_gen #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [WIDTH-1:0] EXC_VEC = DEF_EXC_VEC,
  parameter int INC = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             br_taken_i,
  input  logic [WIDTH-1:0] br_target_i,
  input  logic             jmp_i,
  input  logic [WIDTH-1:0] jmp_target_i,
  input  logic             exc_req_i,
  input  logic [WIDTH-1:0] exc_epc_i,
  input  logic             eret_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] epc_o,
  output logic             in_handler_o,
  output logic             redirect_o,
  output logic             misalign_o,
  output logic [CNT_W-1:0] exc_count_o
);
  state_t state, state_next;
  sel_t sel;
  logic [WIDTH-1:0] next_pc;
  pc_next_sel #(.WIDTH(WIDTH), .EXC_VEC(EXC_VEC), .INC(INC)) u_sel (
    .in_handler(state == HANDLER),
    .stall_i(stall_i),
    .br_taken_i(br_taken_i),
    .br_target_i(br_target_i),
    .jmp_i(jmp_i),
    .jmp_target_i(jmp_target_i),
    .exc_req_i(exc_req_i),
    .eret_i(eret_i),
    .pc(pc_o),
    .epc(epc_o),
    .sel(sel),
    .next_pc(next_pc)
  );
  always_comb begin
    state_next = (sel == SEL_EXC) ? HANDLER : (sel == SEL_ERET) ? NORMAL : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= NORMAL;
      pc_o <= RESET_VEC;
      epc_o <= '0;
      redirect_o <= 1'b0;
      misalign_o <= RESET_VEC[1:0] != 2'b00;
      exc_count_o <= '0;
    end else begin
      state <= state_next;
      pc_o <= next_pc;
      redirect_o <= sel inside {SEL_EXC, SEL_ERET, SEL_BR, SEL_JMP};
      misalign_o <= next_pc[1:0] != 2'b00;
      if (sel == SEL_EXC) begin
        epc_o <= exc_epc_i;
        exc_count_o <= (&exc_count_o) ? exc_count_o : exc_count_o + CNT_W'(1);
      end
    end
  end
  assign in_handler_o = state == HANDLER;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scenario tests for pc_gen with hand-computed expectations.
module tb_pc_gen;
  logic clk = 0, rst = 1;
  logic stall_i = 0, br_taken_i = 0, jmp_i = 0, exc_req_i = 0, eret_i = 0;
  logic [31:0] br_target_i = 0, jmp_target_i = 0, exc_epc_i = 0;
  logic [31:0] pc_o, epc_o;
  logic in_handler_o, redirect_o, misalign_o;
  logic [7:0] exc_count_o;
  int total = 0, bad = 0;

  pc_gen dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .br_taken_i(br_taken_i), .br_target_i(br_target_i),
    .jmp_i(jmp_i), .jmp_target_i(jmp_target_i), .exc_req_i(exc_req_i), .exc_epc_i(exc_epc_i),
    .eret_i(eret_i), .pc_o(pc_o), .epc_o(epc_o), .in_handler_o(in_handler_o),
    .redirect_o(redirect_o), .misalign_o(misalign_o), .exc_count_o(exc_count_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    {stall_i, br_taken_i, jmp_i, exc_req_i, eret_i} = '0;
  endtask

  task automatic test_reset;
    #3;
    total++; if (pc_o !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc_o, 32'h0); end
    total++; if (epc_o !== 32'h0) begin bad++; $display("FAIL reset_epc got=%h exp=%h", epc_o, 32'h0); end
    total++; if ({in_handler_o, redirect_o, misalign_o} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {in_handler_o, redirect_o, misalign_o}); end
    total++; if (exc_count_o !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", exc_count_o); end
    @(negedge clk);
    rst = 0;
    for (int i = 1; i <= 3; i++) begin
      tick;
      total++; if (pc_o !== 32'(i * 4)) begin bad++; $display("FAIL freerun_pc%0d got=%h exp=%h", i, pc_o, 32'(i * 4)); end
      total++; if ({redirect_o, in_handler_o} !== 2'b00) begin bad++; $display("FAIL freerun_flags%0d got=%b exp=00", i, {redirect_o, in_handler_o}); end
    end
  endtask

  task automatic test_stall_branch;
    jmp_i = 1; jmp_target_i = 32'h100;
    tick;
    total++; if (pc_o !== 32'h100 || redirect_o !== 1'b1) begin bad++; $display("FAIL jmp_100 got=%h/%b exp=100/1", pc_o, redirect_o); end
    idle; stall_i = 1;
    for (int i = 0; i < 2; i++) begin
      tick;
      total++; if (pc_o !== 32'h100 || redirect_o !== 1'b0) begin bad++; $display("FAIL stall%0d got=%h/%b exp=100/0", i, pc_o, redirect_o); end
    end
    br_taken_i = 1; br_target_i = 32'h200;
    tick;
    total++; if (pc_o !== 32'h200 || redirect_o !== 1'b1) begin bad++; $display("FAIL br_over_stall got=%h/%b exp=200/1", pc_o, redirect_o); end
    idle;
  endtask

  task automatic test_exception;
    jmp_i = 1; jmp_target_i = 32'h40;
    tick;
    idle; exc_req_i = 1; exc_epc_i = 32'h3C;
    tick;
    total++; if (pc_o !== 32'h4180 || epc_o !== 32'h3C) begin bad++; $display("FAIL exc_entry got=%h/%h exp=4180/3c", pc_o, epc_o); end
    total++; if (in_handler_o !== 1'b1 || exc_count_o !== 8'd1 || redirect_o !== 1'b1) begin bad++; $display("FAIL exc_state got=%b/%0d/%b exp=1/1/1", in_handler_o, exc_count_o, redirect_o); end
    exc_epc_i = 32'h99;
    tick;
    total++; if (pc_o !== 32'h4184 || epc_o !== 32'h3C || exc_count_o !== 8'd1) begin bad++; $display("FAIL nested_masked got=%h/%h/%0d exp=4184/3c/1", pc_o, epc_o, exc_count_o); end
    idle; eret_i = 1;
    tick;
    total++; if (pc_o !== 32'h3C || in_handler_o !== 1'b0 || redirect_o !== 1'b1) begin bad++; $display("FAIL eret got=%h/%b/%b exp=3c/0/1", pc_o, in_handler_o, redirect_o); end
    idle;
  endtask

  task automatic test_priority;
    exc_req_i = 1; exc_epc_i = 32'h60; br_taken_i = 1; br_target_i = 32'h500; jmp_i = 1; jmp_target_i = 32'h600;
    tick;
    total++; if (pc_o !== 32'h4180 || exc_count_o !== 8'd2) begin bad++; $display("FAIL exc_wins got=%h/%0d exp=4180/2", pc_o, exc_count_o); end
    idle; exc_req_i = 1; eret_i = 1; exc_epc_i = 32'h88;
    tick;
    total++; if (pc_o !== 32'h60 || in_handler_o !== 1'b0 || exc_count_o !== 8'd2) begin bad++; $display("FAIL eret_over_exc got=%h/%b/%0d exp=60/0/2", pc_o, in_handler_o, exc_count_o); end
    idle; br_taken_i = 1; jmp_i = 1;
    tick;
    total++; if (pc_o !== 32'h500) begin bad++; $display("FAIL br_over_jmp got=%h exp=500", pc_o); end
    idle; eret_i = 1;
    tick;
    total++; if (pc_o !== 32'h504 || redirect_o !== 1'b0) begin bad++; $display("FAIL eret_in_normal got=%h/%b exp=504/0", pc_o, redirect_o); end
    idle;
  endtask

  task automatic test_wrap_misalign;
    jmp_i = 1; jmp_target_i = 32'hFFFF_FFFC;
    tick;
    idle;
    tick;
    total++; if (pc_o !== 32'h0 || redirect_o !== 1'b0) begin bad++; $display("FAIL wrap got=%h/%b exp=0/0", pc_o, redirect_o); end
    jmp_i = 1; jmp_target_i = 32'h102;
    tick;
    total++; if (pc_o !== 32'h102 || misalign_o !== 1'b1) begin bad++; $display("FAIL misalign got=%h/%b exp=102/1", pc_o, misalign_o); end
    idle;
    tick;
    total++; if (pc_o !== 32'h106 || misalign_o !== 1'b1) begin bad++; $display("FAIL misalign_seq got=%h/%b exp=106/1", pc_o, misalign_o); end
    jmp_i = 1; jmp_target_i = 32'h200;
    tick;
    total++; if (misalign_o !== 1'b0) begin bad++; $display("FAIL align_again got=%b exp=0", misalign_o); end
    idle;
  endtask

  task automatic test_async_reset;
    exc_req_i = 1; exc_epc_i = 32'h70;
    tick;
    idle; eret_i = 1;
    #2 rst = 1;
    #1;
    total++; if (pc_o !== 32'h0 || epc_o !== 32'h0 || exc_count_o !== 8'd0) begin bad++; $display("FAIL async_rst_regs got=%h/%h/%0d exp=0/0/0", pc_o, epc_o, exc_count_o); end
    total++; if ({in_handler_o, redirect_o, misalign_o} !== 3'b000) begin bad++; $display("FAIL async_rst_flags got=%b exp=000", {in_handler_o, redirect_o, misalign_o}); end
    idle;
    #1 rst = 0;
    tick;
    total++; if (pc_o !== 32'h4 || in_handler_o !== 1'b0) begin bad++; $display("FAIL post_rst got=%h/%b exp=4/0", pc_o, in_handler_o); end
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 260; i++) begin
      idle; exc_req_i = 1;
      tick;
      idle; eret_i = 1;
      tick;
    end
    idle;
    total++; if (exc_count_o !== 8'hFF) begin bad++; $display("FAIL count_saturate got=%0d exp=255", exc_count_o); end
  endtask

  initial begin
    test_reset;
    test_stall_branch;
    test_exception;
    test_priority;
    test_wrap_misalign;
    test_async_reset;
    test_saturate;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator for the IF stage of the pipelined MIPS core with interrupt support.
- Holds the fetch PC and advances it sequentially.
- Applies branch, jump, exception/interrupt entry and ERET redirects in a fixed priority.
- Captures the EPC on exception entry and tracks handler state so that nested requests are masked.
- All state updates on the rising edge only; there is no negedge staging register.

Parameters:
WIDTH, 32, PC/address width in bits
RESET_VEC, 32'h0000_0000, pc_o value at reset
EXC_VEC, 32'h0000_4180, exception/interrupt handler entry address
INC, 4, sequential increment in bytes
CNT_W, 8, width of saturating exception-entry counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
stall_i  in  1  hold PC (hazard/memory stall)
br_taken_i  in  1  resolved branch taken
br_target_i  in  WIDTH  branch target
jmp_i  in  1  jump/jr request
jmp_target_i  in  WIDTH  jump target
exc_req_i  in  1  exception/interrupt request from later stage
exc_epc_i  in  WIDTH  PC to resume at after handler
eret_i  in  1  return from handler
pc_o  out  WIDTH  current fetch PC
epc_o  out  WIDTH  saved exception PC
in_handler_o  out  1  1 while in HANDLER state
redirect_o  out  1  1 for one cycle after any accepted redirect, concurrent with new pc_o
misalign_o  out  1  pc_o[1:0] != 0 (registered with pc_o)
exc_count_o  out  CNT_W  number of accepted exception entries, saturating

Behaviour:
- Reset (asynchronous, any time, including mid-redirect or while in HANDLER):
  - pc_o=RESET_VEC, epc_o=0, state=NORMAL, in_handler_o=0.
  - redirect_o=0, misalign_o=RESET_VEC[1:0]!=0, exc_count_o=0.
- FSM states:
  - NORMAL -> HANDLER on accepted exc_req_i.
  - HANDLER -> NORMAL on eret_i.
  - No other transitions.
- Next-PC priority, highest first, evaluated each rising edge:
  1. exc_req_i && NORMAL: pc<=EXC_VEC, epc<=exc_epc_i, count+1 (saturates at all-ones), redirect.
  2. eret_i && HANDLER: pc<=epc_o, redirect.
  3. br_taken_i: pc<=br_target_i, redirect.
  4. jmp_i: pc<=jmp_target_i, redirect.
  5. stall_i: pc holds, redirect_o<=0.
  6. Otherwise: pc<=pc+INC, modulo 2^WIDTH (wraps from all-ones region to low addresses, no flag).
- Redirect and stall:
  - Redirects (1-4) override stall_i, because the redirected stage is flushed.
  - A stall never delays a redirect.
- Masked and ignored requests:
  - exc_req_i in HANDLER is ignored: no EPC overwrite, no count. Evaluation falls through to lower priorities.
  - eret_i in NORMAL is ignored and falls through.
  - Simultaneous exc_req_i and eret_i in HANDLER: eret is taken, the exception is dropped (requester must re-assert).
- Latency: exactly one cycle from request to new pc_o; redirect_o asserts in that same cycle.
- epc_o holds except on accepted exception entry. It is readable throughout HANDLER.
- misalign_o is a status only; pc_gen does not trap on it. Targets are loaded unmodified.

Decomposition:
- Shared package pc_gen_pkg:
  - state enum {NORMAL, HANDLER};
  - next-PC select encoding {SEL_EXC, SEL_ERET, SEL_BR, SEL_JMP, SEL_HOLD, SEL_SEQ};
  - default RESET_VEC/EXC_VEC constants shared with the CP0 block.
- One sub-module, pc_next_sel: combinational priority encoder producing the select code plus a mux producing the next PC.
- pc_gen keeps the registers, the FSM and the counter.

Test Plan:
- Reset then 3 free-run cycles, no requests -> pc_o 0x0, 0x4, 0x8, 0xC; redirect_o=0; in_handler_o=0.
- pc_o=0x100, stall_i=1 for 2 cycles then br_taken_i=1, target 0x200, with stall still 1 -> pc_o 0x100, 0x100, then 0x200 with redirect_o=1 in that cycle.
- pc_o=0x40, exc_req_i=1 with exc_epc_i=0x3C -> pc_o=0x4180, epc_o=0x3C, in_handler_o=1, exc_count_o=1. A second exc_req_i inside the handler -> epc_o stays 0x3C, count stays 1, pc advances to 0x4184. eret_i -> pc_o=0x3C, in_handler_o=0.
- Same cycle exc_req_i + br_taken_i (target 0x500) + jmp_i in NORMAL -> pc_o=0x4180. Same cycle br_taken_i + jmp_i -> branch target wins.
- jmp_i to 0xFFFF_FFFC then free run -> pc_o wraps to 0x0; jmp_i to 0x102 -> misalign_o=1 in the next cycle.
- Assert rst asynchronously mid-cycle while in HANDLER with a pending eret_i -> outputs go to reset values immediately, before the next clk edge. After release, pc_o counts from 0x0.
